cnt_seq_checker: RTL and testbench

CNT_SEQ_CHECKER -- requirements
Module: cnt_seq_checker

---
 rtl/cnt_seq_checker.sv | 135 +++++++++++++
 tb/tb_cnt_seq_checker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_seq_checker.sv
// -----------------------------------------------------------------------------
// cnt_seq_checker
//
// Watches an 8-bit free-running counter and its carry-out and decides whether
// the pair behaves like a proper modulo-256 up-counter. Each sample is compared
// against the previous sample plus one, and the carry must be high exactly when
// the count is 255.
//
// The checker hunts until LOCK_N consecutive good samples arrive. It then sits
// in LOCKED. In LOCKED, a bad sample raises a one-cycle error pulse, bumps the
// saturating error count and drops back to HUNT. Every 255->0 wrap seen while
// locked is counted.
//
// Ports
//   I_clk       : clock, all logic on the rising edge
//   I_rst_n     : synchronous active-low reset
//   I_cnt       : count value under check, sampled every clock
//   I_cout      : carry-out under check, sampled every clock
//   I_clr       : synchronous clear of O_err_cnt / O_wrap_cnt only
//   O_locked    : high while in LOCKED
//   O_err       : one-cycle pulse per error detected while locked
//   O_err_cnt   : saturating (255) error count
//   O_wrap_cnt  : modulo-2^WRAP_W count of 255->0 wraps seen while locked
// -----------------------------------------------------------------------------
module cnt_seq_checker #(
  parameter int LOCK_N = 4,   // good samples needed to lock, 1..15
  parameter int WRAP_W = 16   // width of the wrap counter
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic [7:0]        I_cnt,
  input  logic              I_cout,
  input  logic              I_clr,
  output logic              O_locked,
  output logic              O_err,
  output logic [7:0]        O_err_cnt,
  output logic [WRAP_W-1:0] O_wrap_cnt
);

  typedef enum logic {HUNT, LOCKED} state_t;

  // The run counter tops out at LOCK_N-1; the next good sample locks.
  localparam logic [3:0] RUN_LAST = 4'(LOCK_N - 1);

  state_t              state_q, state_d;
  logic [3:0]          run_q, run_d;
  logic [7:0]          prev_q;
  logic                prev_valid_q;
  logic                err_d;
  logic [7:0]          err_cnt_d;
  logic [WRAP_W-1:0]   wrap_cnt_d;

  logic [7:0]          exp_cnt;
  logic                exp_cout;
  logic                good;
  logic                wrap_seen;

  // The 8-bit add wraps 255 to 0 on its own, which is exactly the expected
  // successor. The expected carry depends on the current sample, not on prev.
  assign exp_cnt   = prev_q + 8'd1;
  assign exp_cout  = (I_cnt == 8'hFF);
  assign good      = (I_cnt == exp_cnt) && (I_cout == exp_cout);
  assign wrap_seen = (prev_q == 8'hFF) && (I_cnt == 8'h00);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    state_d    = state_q;
    run_d      = run_q;
    err_d      = 1'b0;
    err_cnt_d  = O_err_cnt;
    wrap_cnt_d = O_wrap_cnt;

    // The very first sample after reset only primes prev and is not judged.
    if (prev_valid_q) begin
      unique case (state_q)
        HUNT: begin
          if (!good) begin
            run_d = 4'd0;
          end else if (run_q == RUN_LAST) begin
            state_d = LOCKED;
            run_d   = 4'd0;
          end else begin
            run_d = run_q + 4'd1;
          end
        end
        LOCKED: begin
          if (good) begin
            if (wrap_seen) wrap_cnt_d = O_wrap_cnt + WRAP_W'(1);
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
            run_d   = 4'd0;
            if (O_err_cnt != 8'hFF) err_cnt_d = O_err_cnt + 8'd1;
          end
        end
      endcase
    end

    // Clear wins over any increment in the same cycle; it leaves the FSM,
    // the run counter, prev and the error pulse alone.
    if (I_clr) begin
      err_cnt_d  = 8'd0;
      wrap_cnt_d = '0;
    end
  end

  always_ff @(posedge I_clk) begin
    // NOTE: reset here is synchronous, so it is just the highest-priority
    // branch of the clocked block; every register, outputs included, is
    // cleared so nothing leaks across a mid-run reset.
    if (!I_rst_n) begin
      state_q      <= HUNT;
      run_q        <= 4'd0;
      prev_q       <= 8'd0;
      prev_valid_q <= 1'b0;
      O_locked     <= 1'b0;
      O_err        <= 1'b0;
      O_err_cnt    <= 8'd0;
      O_wrap_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state_q      <= state_d;
      run_q        <= run_d;
      prev_q       <= I_cnt;   // the offending sample also becomes prev
      prev_valid_q <= 1'b1;
      O_locked     <= (state_d == LOCKED);
      O_err        <= err_d;
      O_err_cnt    <= err_cnt_d;
      O_wrap_cnt   <= wrap_cnt_d;
    end
  end

endmodule

// File: tb/tb_cnt_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_cnt_seq_checker
//
// Scoreboard bench for cnt_seq_checker. The stimulus process drives one sample
// per clock on the falling edge, advances a behavioural model of the checker
// and queues the outputs expected after the next rising edge. A separate
// monitor pops one entry per rising edge and compares all four outputs.
// Directed scenarios add a few absolute checks at notable points.
// -----------------------------------------------------------------------------
module tb_cnt_seq_checker;

  localparam int LOCK_N = 4;
  localparam int WRAP_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        cnt = 8'd0;
  logic              cout = 1'b0;
  logic              clr = 1'b0;
  logic              locked;
  logic              err;
  logic [7:0]        err_cnt;
  logic [WRAP_W-1:0] wrap_cnt;

  always #5 clk = ~clk;

  cnt_seq_checker #(.LOCK_N(LOCK_N), .WRAP_W(WRAP_W)) dut (
    .I_clk      (clk),
    .I_rst_n    (rst_n),
    .I_cnt      (cnt),
    .I_cout     (cout),
    .I_clr      (clr),
    .O_locked   (locked),
    .O_err      (err),
    .O_err_cnt  (err_cnt),
    .O_wrap_cnt (wrap_cnt)
  );

  typedef struct {
    bit locked;
    bit err;
    int err_cnt;
    int wrap_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state: plain integers.
  bit m_locked, m_pv, m_err;
  int m_run, m_prev, m_ec, m_wc;
  int cur;   // last value driven, used to build the next correct sample

  task automatic check(string name, longint act, longint req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  function automatic void model_step(int c, bit co, bit cl, bit rn);
    bit ok;
    if (!rn) begin
      m_locked = 0; m_pv = 0; m_run = 0; m_err = 0; m_ec = 0; m_wc = 0;
      m_prev = c;
      return;
    end
    m_err = 0;
    if (m_pv) begin
      ok = (c == (m_prev + 1) % 256) && (co == (c == 255));
      if (m_locked) begin
        if (ok) begin
          if (m_prev == 255 && c == 0) m_wc = (m_wc + 1) % (1 << WRAP_W);
        end else begin
          m_err = 1;
          m_ec = (m_ec < 255) ? m_ec + 1 : 255;
          m_locked = 0;
          m_run = 0;
        end
      end else if (ok) begin
        m_run++;
        if (m_run == LOCK_N) begin
          m_locked = 1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    if (cl) begin
      m_ec = 0;
      m_wc = 0;
    end
    m_prev = c;
    m_pv = 1;
  endfunction

  task automatic apply(int c, bit co, bit cl = 0, bit rn = 1);
    exp_t e;
    @(negedge clk);
    cnt = 8'(c); cout = co; clr = cl; rst_n = rn;
    model_step(c, co, cl, rn);
    e = '{m_locked, m_err, m_ec, m_wc};
    exp_q.push_back(e);
    cur = c;
  endtask

  task automatic next_good(bit cl = 0);
    int v;
    v = (cur + 1) % 256;
    apply(v, v == 255, cl);
  endtask

  // Lands just after the edge that consumed the last applied sample.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expected entry per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("locked",   locked,   e.locked);
        check("err",      err,      e.err);
        check("err_cnt",  err_cnt,  e.err_cnt);
        check("wrap_cnt", wrap_cnt, e.wrap_cnt);
      end
    end
  end

  initial begin
    int r;
    cur = 0;

    // Reset for two edges.
    apply(0, 0, 0, 0);
    apply(0, 0, 0, 0);
    after_edge();
    check("rst_locked", locked, 0);
    check("rst_errcnt", err_cnt, 0);

    // Lock on a clean count from 0: sample 0 only primes, 1..4 lock.
    apply(0, 0);
    next_good(); next_good(); next_good();
    after_edge();
    check("prelock", locked, 0);
    next_good();
    after_edge();
    check("lock_at_4", locked, 1);
    check("lock_err", err, 0);

    // 600 samples total from 0: two wraps while locked.
    repeat (595) next_good();
    after_edge();
    check("wrap600", wrap_cnt, 2);
    check("err600", err_cnt, 0);
    check("locked600", locked, 1);

    // Skip 11: ... 10, 12 -> one error, then 13..16 relock.
    while (cur != 10) next_good();
    apply(12, 0);
    after_edge();
    check("skip_err", err, 1);
    check("skip_errcnt", err_cnt, 1);
    check("skip_unlock", locked, 0);
    next_good();
    after_edge();
    check("err_one_cycle", err, 0);
    next_good(); next_good(); next_good();
    after_edge();
    check("relock_16", locked, 1);

    // Clear stats, then carry faults at 255 and 100.
    next_good(1);
    after_edge();
    check("clr_errcnt", err_cnt, 0);
    check("clr_locked", locked, 1);
    while (cur != 254) next_good();
    apply(255, 0);
    after_edge();
    check("cout0_at_255", err, 1);
    check("cout0_errcnt", err_cnt, 1);
    next_good(); next_good(); next_good(); next_good();
    after_edge();
    check("relock_0_3", locked, 1);
    while (cur != 99) next_good();
    apply(100, 1);
    after_edge();
    check("cout1_at_100", err, 1);
    check("cout1_errcnt", err_cnt, 2);

    // 300 errors: lock, break, repeat -> saturation.
    repeat (300) begin
      repeat (LOCK_N) next_good();
      if ($urandom_range(0, 1) == 0) begin
        r = (cur + 2) % 256;
        apply(r, r == 255);
      end else begin
        r = (cur + 1) % 256;
        apply(r, r != 255);
      end
    end
    after_edge();
    check("errcnt_sat", err_cnt, 255);

    // Clear on the very cycle of an error.
    repeat (LOCK_N) next_good();
    r = (cur + 2) % 256;
    apply(r, r == 255, 1);
    after_edge();
    check("clr_vs_err_pulse", err, 1);
    check("clr_vs_err_cnt", err_cnt, 0);

    // Mid-run reset while locked at 200, resume at 50.
    repeat (LOCK_N) next_good();
    while (cur != 200) next_good();
    after_edge();
    check("locked_200", locked, 1);
    apply(201, 1, 1, 0);
    after_edge();
    check("midrst_locked", locked, 0);
    check("midrst_err", err, 0);
    check("midrst_errcnt", err_cnt, 0);
    check("midrst_wrap", wrap_cnt, 0);
    apply(50, 0);
    next_good(); next_good(); next_good();
    after_edge();
    check("post_rst_53", locked, 0);
    next_good();
    after_edge();
    check("post_rst_54", locked, 1);

    // Random mix: mostly clean counting with faults, clears and resets.
    repeat (3000) begin
      r = $urandom_range(0, 99);
      if (r < 2)       apply($urandom_range(0, 255), 1'($urandom_range(0, 1)), 0, 0);
      else if (r < 10) apply($urandom_range(0, 255), 1'($urandom_range(0, 1)));
      else             next_good($urandom_range(0, 49) == 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
